// File: rtl/scan_sel_mux_pkg.sv
// Shared mode encoding, default geometry and index helper for the scan selector.
// Latency: none (declarations only).
// Backpressure: not applicable.
package scan_mux_pkg;

  // Operating modes, 2-bit encoding covers every value
  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_STEP   = 2'b10,
    MODE_FREEZE = 2'b11
  } mode_e;

  // Default geometry matches the legacy 16-to-1, 32-bit debug mux
  localparam int DEF_WIDTH    = 32;
  localparam int DEF_CHANNELS = 16;
  localparam int DEF_DWELL_W  = 26;

  // Modular channel arithmetic: (base + off) wrapped into 0..n-1
  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/scan_sel_mux_if.sv
// Bundle of control, data and result signals between the debug taps and the selector.
// Latency: none (wires only).
// Backpressure: none; the selector samples every cycle.
interface scan_sel_mux_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 16,
  parameter int DWELL_W  = 26,
  parameter int SEL_W    = $clog2(CHANNELS)
);

  logic [1:0]               mode;
  logic [SEL_W-1:0]         s;
  logic [CHANNELS-1:0]      en_mask;
  logic [DWELL_W-1:0]       dwell;
  logic                     step;
  logic [CHANNELS*WIDTH-1:0] data;
  logic [WIDTH-1:0]         o;
  logic [SEL_W-1:0]         ch;
  logic                     upd;

  // Source side: drives mode/select/data, observes the selected word
  modport master (
    output mode, s, en_mask, dwell, step, data,
    input  o, ch, upd
  );

  // Selector side: consumes controls and data, produces the registered word
  modport slave (
    input  mode, s, en_mask, dwell, step, data,
    output o, ch, upd
  );

endinterface

// File: rtl/scan_sel_mux_next_en_ch.sv
// Wrap-around priority search: first enabled channel after cur (cur itself is the last candidate).
// Latency: purely combinational.
// Backpressure: none.
module next_en_ch
  import scan_mux_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [SEL_W-1:0]    i_cur,
  input  logic [CHANNELS-1:0] i_en_mask,
  output logic [SEL_W-1:0]    o_nxt,
  output logic                o_found
);

  // Doubling the mask lets a plain right shift express the wrap: after shifting
  // by cur+1, bit j of the low half is the enable of channel (cur+1+j) mod N.
  logic [2*CHANNELS-1:0] w_dbl;
  logic [2*CHANNELS-1:0] w_rot_full;
  logic [CHANNELS-1:0]   w_rot;
  int                    w_off;
  logic                  w_any;

  assign w_dbl      = {i_en_mask, i_en_mask};
  assign w_rot_full = w_dbl >> (int'(i_cur) + 1);
  assign w_rot      = w_rot_full[CHANNELS-1:0];

  // Lowest set bit of the rotated mask is the nearest enabled channel forward of cur
  always_comb begin
    w_off = 0;
    w_any = 1'b0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off = j;
        w_any = 1'b1;
      end
    end
  end

  // Convert the forward offset back to an absolute index; hold cur when nothing is enabled
  always_comb begin
    o_nxt   = i_cur;
    o_found = w_any;
    if (w_any) begin
      o_nxt = SEL_W'(wrap_add(int'(i_cur), w_off + 1, CHANNELS));
    end
  end

endmodule

// File: rtl/scan_sel_mux.sv
// Registered N-channel word selector with manual, auto-scan, single-step and freeze modes.
// Latency: one cycle from s/data/step to o/ch/upd; mode acts in the cycle it is presented.
// Backpressure: none; o/ch/upd refresh every non-freeze cycle, freeze holds them.
module scan_sel_mux
  import scan_mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DWELL_W  = DEF_DWELL_W,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic           clk,
  input  logic           rst,
  scan_sel_mux_if.slave  bus
);

  localparam int unsigned          CH_U    = CHANNELS;
  localparam logic [DWELL_W-1:0]   CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  mode_e               w_mode;
  logic                w_s_valid;
  logic                w_step_rise;
  logic                w_expired;
  logic [SEL_W-1:0]    w_nxt;
  logic                w_found;
  logic [SEL_W-1:0]    w_ch_next;
  logic [DWELL_W-1:0]  w_cnt_next;
  logic [WIDTH-1:0]    w_sel_word;

  logic [SEL_W-1:0]    r_ch;
  logic [WIDTH-1:0]    r_o;
  logic                r_upd;
  logic [DWELL_W-1:0]  r_cnt;
  logic                r_step_q;

  assign w_mode      = mode_e'(bus.mode);
  // A select beyond the last channel is ignored rather than aliased
  assign w_s_valid   = (32'(bus.s) < CH_U);
  assign w_step_rise = bus.step & ~r_step_q;
  // Compared against the live dwell, so a mid-count change takes effect at once
  assign w_expired   = (r_cnt == bus.dwell);

  // One search engine shared by auto-scan and single-step
  next_en_ch #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_next_en_ch (
    .i_cur     (r_ch),
    .i_en_mask (bus.en_mask),
    .o_nxt     (w_nxt),
    .o_found   (w_found)
  );

  // Next channel and dwell count from the current mode
  always_comb begin
    w_ch_next  = r_ch;
    w_cnt_next = '0;
    case (w_mode)
      MODE_MANUAL: begin
        if (w_s_valid) begin
          w_ch_next = bus.s;
        end
      end
      MODE_AUTO: begin
        if (w_expired) begin
          if (w_found) begin
            w_ch_next = w_nxt;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      MODE_STEP: begin
        if (w_step_rise && w_found) begin
          w_ch_next = w_nxt;
        end
      end
      MODE_FREEZE: begin
        w_ch_next = r_ch;
      end
      default: begin
        w_ch_next = r_ch;
      end
    endcase
  end

  // Word slice for the channel that will be shown next, so o and ch stay coherent
  always_comb begin
    w_sel_word = bus.data[int'(w_ch_next)*WIDTH +: WIDTH];
  end

  // Dwell counter and step edge history; the counter is zero outside auto-scan
  // (freeze included) so every entry into auto-scan starts a full dwell
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_step_q <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_step_q <= bus.step;
    end
  end

  // Channel, word and change strobe; freeze holds the display and drops the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch  <= '0;
      r_o   <= '0;
      r_upd <= 1'b0;
    end else if (w_mode != MODE_FREEZE) begin
      r_ch  <= w_ch_next;
      r_o   <= w_sel_word;
      r_upd <= (w_ch_next != r_ch);
    end else begin
      r_upd <= 1'b0;
    end
  end

  assign bus.o   = r_o;
  assign bus.ch  = r_ch;
  assign bus.upd = r_upd;

endmodule
